keystroke_cipher_ctrl: RTL
==========================

KEYSTROKE_CIPHER_CTRL -- requirements
Module: keystroke_cipher_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning ciphertext buffer entries (power of 2, 2..64).
REQ-002 SHALL have parameter WAIT_CYCLES, default 5000, meaning cycles o_rotate stays high after key release (1..65535).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_scan_data  in  8  PS/2 received byte.
REQ-006 SHALL have port i_scan_en  in  1  one-cycle strobe qualifying i_scan_data.
REQ-007 SHALL have port o_plain_code  out  8  latched make code of current key.
REQ-008 SHALL have port o_plain_ext  out  1  latched key carried E0 prefix.
REQ-009 SHALL have port o_enc_start  out  1  one-cycle request to cipher engine.
REQ-010 SHALL have port i_enc_data  in  8  cipher engine result.
REQ-011 SHALL have port i_enc_valid  in  1  qualifies i_enc_data.
REQ-012 SHALL have port o_rotate  out  1  rotor-advance level to cipher engine.
REQ-013 SHALL have port o_ct_data  out  8  head of ciphertext FIFO.
REQ-014 SHALL have port o_ct_valid  out  1  FIFO non-empty.
REQ-015 SHALL have port i_ct_ready  in  1  consumer pop; pop occurs when o_ct_valid && i_ct_ready.
REQ-016 SHALL have port o_ct_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port o_overflow  out  1  sticky: a result was dropped because FIFO full.
REQ-018 SHALL have port o_state  out  3  encoded FSM state for LED debug.

Function
REQ-019 FSM SHALL have states IDLE, SKIP, ENC, HELD, BREAK, WAIT; bytes without i_scan_en SHALL be ignored.
REQ-020 IDLE: E0 sets ext flag, stay; F0 -> SKIP; any other byte latches o_plain_code/o_plain_ext (ext flag), clears ext flag, pulses o_enc_start next cycle, -> ENC.
REQ-021 SKIP (stray release): next byte discarded, ext flag cleared, -> IDLE.
REQ-022 ENC: F0 sets brk_pending; other bytes ignored; on i_enc_valid push i_enc_data, then -> BREAK if brk_pending (or F0 same cycle) else HELD.
REQ-023 HELD: typematic repeats, E0 and other make codes ignored (no re-encode); F0 -> BREAK.
REQ-024 BREAK: byte equal to o_plain_code -> WAIT, clear counter; E0 and non-matching bytes stay.
REQ-025 WAIT: o_rotate high for exactly WAIT_CYCLES cycles, then -> IDLE; bytes received during WAIT discarded.
REQ-026 o_rotate SHALL be low in all states except WAIT.
REQ-027 Latency: o_enc_start one cycle after accepting make byte; FIFO push registered, o_ct_valid high the cycle after i_enc_valid if empty.
REQ-028 FIFO SHALL be show-ahead; full push drops data, sets o_overflow, count unchanged.
REQ-029 Simultaneous push and pop when full SHALL accept both; count unchanged, no overflow.
REQ-030 Simultaneous push and pop when empty SHALL push only (pop not qualified).
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count saturates never beyond FIFO_DEPTH.
REQ-032 i_enc_valid outside ENC SHALL be ignored.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, o_plain_code=00, o_plain_ext=0, o_enc_start=0, o_rotate=0, FIFO empty (o_ct_valid=0, o_ct_count=0), o_overflow=0, counters and flags 0.
REQ-034 Reset asserted mid-operation (any state) SHALL discard pending keystroke and FIFO contents; first post-reset byte treated from IDLE.

Structure
REQ-035 Package keystroke_cipher_pkg SHALL hold state enum, SCAN_EXT=8'hE0, SCAN_BREAK=8'hF0.
REQ-036 FIFO SHALL be sub-module cipher_fifo (parameter DEPTH, width 8, same clock/reset).

Verification
REQ-037 Bytes 1C, F0, 1C; engine returns 5A 3 cycles after start -> one o_enc_start, FIFO holds 5A, o_rotate high exactly WAIT_CYCLES cycles, back to IDLE.
REQ-038 Bytes E0, 75, 75, 75, E0, F0, 75 -> o_plain_ext=1, o_plain_code=75, single o_enc_start, one FIFO entry.
REQ-039 F0 during ENC then valid -> FSM goes ENC->BREAK directly; subsequent 1C -> WAIT.
REQ-040 FIFO_DEPTH=4, i_ct_ready=0, five keystrokes -> o_ct_count=4, o_overflow=1, first four results read in order.
REQ-041 Full FIFO, i_ct_ready=1 coincident with push -> count stays 4, o_overflow stays 0, order preserved.
REQ-042 reset_n low during WAIT with 2 FIFO entries -> o_rotate=0, o_ct_valid=0 immediately; stray F0, 1C after reset -> no o_enc_start.

Source files
------------

// File: rtl/keystroke_cipher_pkg.sv
// Shared types and scan-code constants for the keystroke cipher controller.
package keystroke_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    ENC   = 3'd2,
    HELD  = 3'd3,
    BREAK = 3'd4,
    WAIT  = 3'd5
  } state_t;

  localparam logic [7:0] SCAN_EXT   = 8'hE0;
  localparam logic [7:0] SCAN_BREAK = 8'hF0;

endpackage

// File: rtl/cipher_fifo.sv
// Show-ahead 8-bit ciphertext FIFO with sticky overflow flag.
module cipher_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keystroke_cipher_ctrl.sv
// Turns PS/2 make/break sequences into one cipher request per keystroke,
// buffers results, and holds the rotor-advance level after each release.
module keystroke_cipher_ctrl
  import keystroke_cipher_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_CYCLES = 5000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic [7:0]                    i_scan_data,
  input  logic                          i_scan_en,
  output logic [7:0]                    o_plain_code,
  output logic                          o_plain_ext,
  output logic                          o_enc_start,
  input  logic [7:0]                    i_enc_data,
  input  logic                          i_enc_valid,
  output logic                          o_rotate,
  // Ciphertext stream: an entry leaves on a cycle with o_ct_valid && i_ct_ready;
  // o_ct_data holds the head entry and stays stable until that pop.
  output logic [7:0]                    o_ct_data,
  output logic                          o_ct_valid,
  input  logic                          i_ct_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_ct_count,
  output logic                          o_overflow,
  output logic [2:0]                    o_state
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);

  state_t      state;
  logic        ext_flag;
  logic        brk_pending;
  logic [15:0] wait_cnt;
  logic        scan_brk;
  logic        enc_push;

  assign scan_brk = i_scan_en && (i_scan_data == SCAN_BREAK);
  assign enc_push = (state == ENC) && i_enc_valid;
  assign o_state  = state;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      o_plain_code <= 8'h00;
      o_plain_ext  <= 1'b0;
      o_enc_start  <= 1'b0;
      o_rotate     <= 1'b0;
      ext_flag     <= 1'b0;
      brk_pending  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      o_enc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_scan_en) begin
            if (i_scan_data == SCAN_EXT) begin
              ext_flag <= 1'b1;
            end else if (i_scan_data == SCAN_BREAK) begin
              state <= SKIP;
            end else begin
              o_plain_code <= i_scan_data;
              o_plain_ext  <= ext_flag;
              ext_flag     <= 1'b0;
              brk_pending  <= 1'b0;
              o_enc_start  <= 1'b1;
              state        <= ENC;
            end
          end
        end
        SKIP: begin
          if (i_scan_en) begin
            ext_flag <= 1'b0;
            state    <= IDLE;
          end
        end
        ENC: begin
          // A release seen while the engine is busy skips the HELD phase.
          if (scan_brk) brk_pending <= 1'b1;
          if (i_enc_valid) begin
            brk_pending <= 1'b0;
            state       <= (brk_pending || scan_brk) ? BREAK : HELD;
          end
        end
        HELD: begin
          if (scan_brk) state <= BREAK;
        end
        BREAK: begin
          if (i_scan_en && (i_scan_data == o_plain_code)) begin
            wait_cnt <= '0;
            o_rotate <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            o_rotate <= 1'b0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cipher_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .push     (enc_push),
    .din      (i_enc_data),
    .pop      (i_ct_ready),
    .dout     (o_ct_data),
    .valid    (o_ct_valid),
    .count    (o_ct_count),
    .overflow (o_overflow)
  );

endmodule
